mode_counter: RTL

Parametrised up/down counter with runtime limit, wrap/saturate mode, synchronous load, enable prescaler, terminal-count pulse and sticky overflow flag. Successor to the plain enable counter, used wherever the design needs programmable-period timers, event counters or modulo sequencers. Single clock domain. All outputs are registered.

---
 rtl/counter_pkg.sv | 17 +
 rtl/counter_prescaler.sv | 41 ++++
 rtl/mode_counter.sv | 77 +++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the mode counter.
// Direction/mode encodings and a ceiling-log2 for register sizing.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: one tick per prescale accepted enables.
// With prescale = 1 the tick is the enable itself.
module counter_prescaler
    import counter_pkg::*;
#(
    parameter int prescale = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int cl = clog2(prescale);
    localparam int pw = (cl > 1) ? cl : 1;

    generate
        if (prescale == 1) begin : g_bypass
            logic unused_ok;
            assign unused_ok = ^{clk, rst, clr};
            assign tick = en;
        end else begin : g_div
            localparam logic [pw-1:0] last = pw'(prescale - 1);
            logic [pw-1:0] pcnt;

            assign tick = en && (pcnt == last);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pcnt <= '0;
                end else if (clr) begin
                    pcnt <= '0;
                end else if (en) begin
                    pcnt <= tick ? '0 : pcnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mode_counter.sv
// Up/down counter with runtime limit, wrap/saturate, load,
// prescaled enable, terminal-count pulse and sticky overflow.
module mode_counter
    import counter_pkg::*;
#(
    parameter int width    = 8,
    parameter int prescale = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             sat,
    input  logic [width-1:0] limit,
    input  logic             load,
    input  logic [width-1:0] load_val,
    input  logic             clr_ovf,
    output logic [width-1:0] cnt,
    output logic             tc,
    output logic             ovf
);

    logic             tick;
    logic [width-1:0] cnt_n;
    logic             tc_n;
    logic             ovf_n;
    logic             bnd;

    counter_prescaler #(
        .prescale(prescale)
    ) u_pre (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (load),
        .tick(tick)
    );

    always_comb begin
        cnt_n = cnt;
        tc_n  = 1'b0;
        ovf_n = ovf & ~clr_ovf;
        bnd   = 1'b0;
        if (load) begin
            cnt_n = (load_val > limit) ? limit : load_val;
        end else if (tick) begin
            if (dir == DIR_UP) begin
                bnd = (cnt >= limit);
                if (!bnd) cnt_n = cnt + 1'b1;
                else      cnt_n = (sat == MODE_SAT) ? limit : '0;
            end else begin
                // limit = 0 forces a boundary even if cnt sits above it
                bnd = (cnt == '0) || (limit == '0);
                if (bnd)              cnt_n = (sat == MODE_SAT) ? '0 : limit;
                else if (cnt > limit) cnt_n = limit;
                else                  cnt_n = cnt - 1'b1;
            end
            if (bnd) begin
                tc_n  = 1'b1;
                ovf_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            cnt <= cnt_n;
            tc  <= tc_n;
            ovf <= ovf_n;
        end
    end

endmodule
